// File: rtl/instr_loader.sv
// instr_loader: writable 9-bit instruction store with a host load port.
// The host streams words over a valid/ready handshake into internal RAM;
// the fetch side decodes mem[pc_in] into the same fields the fixed ROMs
// provide. While a load is running the core is stalled and fetch sees NOP.
module instr_loader #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic [15:0] load_base,
    input  logic [15:0] load_count,
    input  logic        wr_valid,
    input  logic [8:0]  wr_data,
    output logic        wr_ready,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_err,
    input  logic [15:0] pc_in,
    output logic        format,
    output logic [3:0]  opcode,
    output logic        sign,
    output logic [2:0]  operand,
    output logic [7:0]  immediate
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   addr;
    logic [15:0]     remain;
    logic [DEPTH-1:0] loaded;
    logic [8:0]      mem [DEPTH];

    logic            beat;
    logic [16:0]     req_end;
    logic            req_bad;
    logic            pc_ok;
    logic [AW-1:0]   pc_idx;
    logic [8:0]      fetch_word;

    // One past the last requested address; 17 bits so base+count cannot wrap.
    assign req_end = {1'b0, load_base} + {1'b0, load_count};
    assign req_bad = (req_end > 17'(DEPTH));
    assign beat    = wr_valid & wr_ready;

    // Load sequencer: all handshake/status outputs are registered alongside
    // the state so they change exactly on the state transition edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remain    <= '0;
            loaded    <= '0;
            wr_ready  <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        if (req_bad) begin
                            load_err <= 1'b1;
                        end else begin
                            load_err <= 1'b0;
                            if (load_count == 16'd0) begin
                                state     <= DONE;
                                load_done <= 1'b1;
                            end else begin
                                // base < DEPTH here, so the low bits hold it exactly
                                addr      <= load_base[AW-1:0];
                                remain    <= load_count;
                                state     <= LOAD;
                                load_busy <= 1'b1;
                                wr_ready  <= 1'b1;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (beat) begin
                        loaded[addr] <= 1'b1;
                        addr         <= addr + AW'(1);
                        remain       <= remain - 16'd1;
                        if (remain == 16'd1) begin
                            state     <= DONE;
                            load_busy <= 1'b0;
                            wr_ready  <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    load_busy <= 1'b0;
                    wr_ready  <= 1'b0;
                end
            endcase
        end
    end

    // Instruction RAM write port; contents are deliberately not reset,
    // visibility is governed by the loaded bits instead.
    always_ff @(posedge clk) begin
        if (beat) begin
            mem[addr] <= wr_data;
        end
    end

    assign pc_ok  = (32'(pc_in) < DEPTH);
    assign pc_idx = pc_in[AW-1:0];

    // Combinational fetch: NOP for out-of-range, never-loaded, or mid-load.
    always_comb begin
        fetch_word = 9'b0;
        if (pc_ok && !load_busy && loaded[pc_idx]) begin
            fetch_word = mem[pc_idx];
        end
    end

    assign format    = fetch_word[8];
    assign opcode    = fetch_word[7:4];
    assign sign      = fetch_word[3];
    assign operand   = fetch_word[2:0];
    assign immediate = fetch_word[7:0];

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench. Stimulus pushes expected fetch/status
// records and expected load_done cycles; a monitor on the falling edge pops
// and compares whenever a check is flagged or load_done is seen.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic [15:0] load_base;
    logic [15:0] load_count;
    logic        wr_valid;
    logic [8:0]  wr_data;
    logic        wr_ready;
    logic        load_busy;
    logic        load_done;
    logic        load_err;
    logic [15:0] pc_in;
    logic        format;
    logic [3:0]  opcode;
    logic        sign;
    logic [2:0]  operand;
    logic [7:0]  immediate;

    instr_loader #(.DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_base(load_base), .load_count(load_count),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
        .pc_in(pc_in), .format(format), .opcode(opcode), .sign(sign),
        .operand(operand), .immediate(immediate)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [8:0]  w;
        logic        b;
        logic        r;
        logic        e;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   done_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic chk_en = 1'b0;

    localparam logic [8:0] W0  = 9'b101111000;
    localparam logic [8:0] W1  = 9'b010000000;
    localparam logic [8:0] W2  = 9'b101111001;
    localparam logic [8:0] W3  = 9'b110110000;
    localparam logic [8:0] NOP = 9'b000000000;

    logic [8:0] words [4];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares flagged fetch/status samples and every load_done pulse.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t x;
            logic [19:0] act, expv;
            x = sbq.pop_front();
            act  = {format, opcode, sign, operand, immediate, load_busy, wr_ready, load_err};
            expv = {x.w[8], x.w[7:4], x.w[3], x.w[2:0], x.w[7:0], x.b, x.r, x.e};
            total++;
            if (act !== expv) begin
                bad++;
                $display("FAIL %s pc=%0d got fields/busy/ready/err=%b want=%b", x.nm, x.pc, act, expv);
            end
        end
        if (load_done === 1'b1) begin
            total++;
            if (done_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done cyc=%0d got load_done=1 want 0", cyc);
            end else begin
                int e;
                e = done_q.pop_front();
                if (e != cyc) begin
                    bad++;
                    $display("FAIL done_time got cyc=%0d want cyc=%0d", cyc, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        chk_en = 1'b0;
    endtask

    task automatic expect_at(input logic [15:0] pc, input logic [8:0] w,
                             input logic b, input logic r, input logic e, input string nm);
        exp_t x;
        pc_in = pc;
        x.pc = pc; x.w = w; x.b = b; x.r = r; x.e = e; x.nm = nm;
        sbq.push_back(x);
        chk_en = 1'b1;
    endtask

    task automatic start(input logic [15:0] base, input logic [15:0] cnt);
        load_start = 1'b1;
        load_base  = base;
        load_count = cnt;
        step();
        load_start = 1'b0;
    endtask

    // Back-to-back four-word load; checks base+1 in the done cycle itself.
    task automatic load4(input logic [15:0] base, input logic [8:0] w1_exp, input string nm);
        done_q.push_back(cyc + 5);
        start(base, 16'd4);
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = words[i];
            step();
        end
        wr_valid = 1'b0;
        expect_at(base + 16'd1, w1_exp, 1'b0, 1'b0, 1'b0, nm);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;
        rst_n = 1'b0; load_start = 1'b0; load_base = '0; load_count = '0;
        wr_valid = 1'b0; wr_data = '0; pc_in = '0;
        step(); step();
        expect_at(16'd0, NOP, 1'b0, 1'b0, 1'b0, "in_reset");
        step();
        rst_n = 1'b1;
        step();

        // Reset contents: every address reads NOP, no handshake activity
        for (int p = 0; p <= 300; p++) begin
            expect_at(16'(p), NOP, 1'b0, 1'b0, 1'b0, "reset_sweep");
            step();
        end

        // Basic back-to-back load at base 0
        load4(16'd0, W1, "done_cycle_pc1");
        expect_at(16'd3, W3, 1'b0, 1'b0, 1'b0, "pc3");         step();
        expect_at(16'd4, NOP, 1'b0, 1'b0, 1'b0, "pc4_nop");    step();
        expect_at(16'd0, W0, 1'b0, 1'b0, 1'b0, "pc0");         step();
        expect_at(16'd2, W2, 1'b0, 1'b0, 1'b0, "pc2");         step();

        // Same load with wr_valid every other cycle: 8 busy cycles, pc2 NOP
        done_q.push_back(cyc + 9);
        start(16'd0, 16'd4);
        for (int i = 0; i < 8; i++) begin
            wr_valid = (i % 2) == 1;
            wr_data  = words[i / 2];
            expect_at(16'd2, NOP, 1'b1, 1'b1, 1'b0, "toggle_busy_pc2");
            step();
        end
        wr_valid = 1'b0;
        expect_at(16'd2, W2, 1'b0, 1'b0, 1'b0, "toggle_done_pc2"); step();
        expect_at(16'd3, W3, 1'b0, 1'b0, 1'b0, "toggle_pc3");      step();

        // Rejected request: 250+10 > 256
        start(16'd250, 16'd10);
        wr_valid = 1'b1; wr_data = 9'h1FF;
        expect_at(16'd250, NOP, 1'b0, 1'b0, 1'b1, "err_set");      step();
        expect_at(16'd0, W0, 1'b0, 1'b0, 1'b1, "err_mem_kept");    step();
        wr_valid = 1'b0;
        expect_at(16'd1, W1, 1'b0, 1'b0, 1'b1, "err_sticky");      step();

        // Zero-count start is accepted: clears err, done one cycle later
        done_q.push_back(cyc + 1);
        start(16'd4, 16'd0);
        expect_at(16'd4, NOP, 1'b0, 1'b0, 1'b0, "zero_cnt_clr_err"); step();

        // Exact top-of-memory fit: 252+4 == 256 is legal
        load4(16'd252, W1, "top_pc253");
        expect_at(16'd255, W3, 1'b0, 1'b0, 1'b0, "top_pc255");     step();
        expect_at(16'd256, NOP, 1'b0, 1'b0, 1'b0, "pc256_nop");    step();

        // Reset after two of four beats: nothing visible afterward
        start(16'd0, 16'd4);
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_data = words[i];
            step();
        end
        wr_valid = 1'b0;
        rst_n = 1'b0;
        expect_at(16'd0, NOP, 1'b0, 1'b0, 1'b0, "rst_mid_busy0");  step();
        rst_n = 1'b1;
        step();
        expect_at(16'd0, NOP, 1'b0, 1'b0, 1'b0, "rst_pc0_nop");    step();
        expect_at(16'd1, NOP, 1'b0, 1'b0, 1'b0, "rst_pc1_nop");    step();
        expect_at(16'd255, NOP, 1'b0, 1'b0, 1'b0, "rst_pc255_nop"); step();

        // load_start mid-load (base 7) is ignored
        done_q.push_back(cyc + 5);
        start(16'd0, 16'd4);
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = words[i];
            if (i == 1) begin
                load_start = 1'b1; load_base = 16'd7; load_count = 16'd1;
            end
            step();
            load_start = 1'b0;
        end
        wr_valid = 1'b0;
        expect_at(16'd3, W3, 1'b0, 1'b0, 1'b0, "ign_pc3");         step();
        expect_at(16'd7, NOP, 1'b0, 1'b0, 1'b0, "ign_pc7_nop");    step();
        expect_at(16'd0, W0, 1'b0, 1'b0, 1'b0, "ign_pc0");         step();
        step(); step();

        total++;
        if (done_q.size() != 0) begin
            bad++;
            $display("FAIL missing_done got pending=%0d want 0", done_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
